// File: rtl/datapath_regs.sv
// -----------------------------------------------------------------------------
// datapath_regs
//   Register bank plus shared-bus datapath driven by the processor control FSM.
//   Holds PC, IR, DAR, AC, R and R1-R5. The FSM picks one bus source with
//   i_read_en, loads registers with one-hot i_write_en strobes and bumps
//   registers with i_inc_en strobes. Memory/ALU ports are views of registers.
//
// Ports
//   i_clk          system clock
//   i_reset        synchronous, active-high; clears every register
//   i_read_en      [3:0]   bus source code
//   i_write_en     [15:0]  register load strobes (bit11 = data memory write)
//   i_inc_en       [7:0]   register increment strobes
//   i_alu_result   ALU output, alternate AC load source
//   i_iram_rdata   instruction memory read data
//   i_dram_rdata   data memory read data
//   o_iram_addr    PC
//   o_dram_addr    DAR
//   o_dram_wdata   AC
//   o_dram_we      data memory write strobe (same cycle as write_en[11])
//   o_alu_a        AC
//   o_alu_b        R
//   o_instruction  IR
//   o_z            {0..0, AC==0}
//   o_bus          current bus value
// -----------------------------------------------------------------------------

// One register of the bank: load beats increment, increment wraps.
module datapath_regs_cell #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_ld,
    input  logic [W-1:0] i_ld_data,
    input  logic         i_inc,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset)    r_q <= '0;
        else if (i_ld)  r_q <= i_ld_data;
        else if (i_inc) r_q <= r_q + 1'b1;
    end

    assign o_q = r_q;
endmodule

module datapath_regs #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [3:0]        i_read_en,
    input  logic [15:0]       i_write_en,
    input  logic [7:0]        i_inc_en,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_iram_rdata,
    input  logic [DATA_W-1:0] i_dram_rdata,
    output logic [ADDR_W-1:0] o_iram_addr,
    output logic [ADDR_W-1:0] o_dram_addr,
    output logic [DATA_W-1:0] o_dram_wdata,
    output logic              o_dram_we,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [DATA_W-1:0] o_instruction,
    output logic [DATA_W-1:0] o_z,
    output logic [DATA_W-1:0] o_bus
);
    // Bank slot numbering
    localparam int NREG = 10;
    localparam int PC   = 0;
    localparam int IR   = 1;
    localparam int DAR  = 2;
    localparam int AC   = 3;
    localparam int RR   = 4;
    localparam int R1   = 5;  // R1..R5 occupy slots 5..9

    logic [NREG-1:0]             w_ld;
    logic [NREG-1:0]             w_inc;
    logic [NREG-1:0][DATA_W-1:0] w_ld_data;
    logic [NREG-1:0][DATA_W-1:0] w_q;
    logic [DATA_W-1:0]           w_bus;

    // Bus source mux; unmapped codes read as zero.
    always_comb begin
        w_bus = '0;
        case (i_read_en)
            4'd2:    w_bus = w_q[DAR];
            4'd5:    w_bus = w_q[AC];
            4'd6:    w_bus = w_q[RR];
            4'd7:    w_bus = w_q[R1];
            4'd8:    w_bus = w_q[R1+1];
            4'd9:    w_bus = w_q[R1+2];
            4'd10:   w_bus = w_q[R1+3];
            4'd11:   w_bus = w_q[R1+4];
            4'd12:   w_bus = i_dram_rdata;
            4'd13:   w_bus = i_iram_rdata;
            default: w_bus = '0;
        endcase
    end

    // Strobe decode. AC has two load sources; the ALU strobe takes priority.
    always_comb begin
        w_ld      = '0;
        w_inc     = '0;
        w_ld_data = '{default: w_bus};

        w_ld[PC]  = i_write_en[1];
        w_ld[DAR] = i_write_en[2];
        w_ld[IR]  = i_write_en[3];
        w_ld[AC]  = i_write_en[4] | i_write_en[13];
        w_ld[RR]  = i_write_en[5];
        for (int k = 0; k < 5; k++)
            w_ld[R1+k] = i_write_en[6+k];

        if (i_write_en[13])
            w_ld_data[AC] = i_alu_result;

        w_inc[PC]   = i_inc_en[1];
        w_inc[AC]   = i_inc_en[2];
        w_inc[DAR]  = i_inc_en[3];
        w_inc[R1]   = i_inc_en[4];
        w_inc[R1+1] = i_inc_en[5];
        w_inc[R1+2] = i_inc_en[6];
    end

    // Strobe bits with no function in this block.
    logic w_unused;
    assign w_unused = ^{i_write_en[0], i_write_en[12], i_write_en[15:14],
                        i_inc_en[0], i_inc_en[7]};

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        datapath_regs_cell #(.W(DATA_W)) u_cell (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_ld      (w_ld[g]),
            .i_ld_data (w_ld_data[g]),
            .i_inc     (w_inc[g]),
            .o_q       (w_q[g])
        );
    end

    assign o_bus         = w_bus;
    assign o_dram_we     = i_write_en[11];
    assign o_iram_addr   = ADDR_W'(w_q[PC]);
    assign o_dram_addr   = ADDR_W'(w_q[DAR]);
    assign o_dram_wdata  = w_q[AC];
    assign o_alu_a       = w_q[AC];
    assign o_alu_b       = w_q[RR];
    assign o_instruction = w_q[IR];
    assign o_z           = {{(DATA_W-1){1'b0}}, (w_q[AC] == '0)};
endmodule

// File: tb/tb_datapath_regs.sv
module tb_datapath_regs;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  read_en;
    logic [15:0] write_en;
    logic [7:0]  inc_en;
    logic [15:0] alu_result, iram_rdata, dram_rdata;
    logic [15:0] iram_addr, dram_addr, dram_wdata, alu_a, alu_b, instruction, z, bus;
    logic        dram_we;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    datapath_regs #(.DATA_W(16), .ADDR_W(16)) dut (
        .i_clk(clk), .i_reset(reset), .i_read_en(read_en), .i_write_en(write_en),
        .i_inc_en(inc_en), .i_alu_result(alu_result), .i_iram_rdata(iram_rdata),
        .i_dram_rdata(dram_rdata), .o_iram_addr(iram_addr), .o_dram_addr(dram_addr),
        .o_dram_wdata(dram_wdata), .o_dram_we(dram_we), .o_alu_a(alu_a),
        .o_alu_b(alu_b), .o_instruction(instruction), .o_z(z), .o_bus(bus)
    );

    always #50 clk = ~clk;

    // Reference model: named slots 0 PC,1 IR,2 DAR,3 AC,4 R,5..9 R1..R5.
    // Tables map codes/bits to slots (-1 none, -2 dram_rdata, -3 iram_rdata).
    logic [15:0] m [10];
    int src_tbl [16] = '{-1, -1, 2, -1, -1, 3, 4, 5, 6, 7, 8, 9, -2, -3, -1, -1};
    int ld_tbl  [16] = '{-1, 0, 2, 1, 3, 4, 5, 6, 7, 8, 9, -1, -1, -1, -1, -1};
    int inc_tbl [8]  = '{-1, 0, 3, 2, 5, 6, 7, -1};
    int probe_codes [10] = '{0, 2, 5, 6, 7, 8, 9, 10, 11, 3};

    function automatic logic [15:0] model_bus(input logic [3:0] code);
        int s;
        s = src_tbl[code];
        if (s == -2) return dram_rdata;
        if (s == -3) return iram_rdata;
        if (s < 0)   return 16'h0000;
        return m[s];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check every register view, probing bank contents through the bus.
    task automatic check_all();
        chk("iram_addr", iram_addr, m[0]);
        chk("instruction", instruction, m[1]);
        chk("dram_addr", dram_addr, m[2]);
        chk("alu_a", alu_a, m[3]);
        chk("dram_wdata", dram_wdata, m[3]);
        chk("alu_b", alu_b, m[4]);
        chk("z", z, (m[3] == 16'h0) ? 16'h0001 : 16'h0000);
        for (int i = 0; i < 10; i++) begin
            read_en = probe_codes[i][3:0];
            #1;
            chk($sformatf("probe_bus%0d", probe_codes[i]), bus, model_bus(read_en));
        end
    endtask

    // One clock: drive, check combinational outputs, clock, update model, check.
    task automatic step(input logic rst, input logic [3:0] re, input logic [15:0] we,
                        input logic [7:0] inc, input logic [15:0] alu,
                        input logic [15:0] ir, input logic [15:0] dr);
        logic [15:0] nxt [10];
        logic [15:0] b;
        reset = rst; read_en = re; write_en = we; inc_en = inc;
        alu_result = alu; iram_rdata = ir; dram_rdata = dr;
        #1;
        b = model_bus(re);
        chk("bus", bus, b);
        chk("dram_we", {15'h0, dram_we}, {15'h0, we[11]});
        nxt = m;
        if (rst) begin
            foreach (nxt[i]) nxt[i] = 16'h0;
        end else begin
            for (int i = 0; i < 8; i++)
                if (inc[i] && inc_tbl[i] >= 0) nxt[inc_tbl[i]] = m[inc_tbl[i]] + 16'h1;
            for (int i = 0; i < 16; i++)
                if (we[i] && ld_tbl[i] >= 0) nxt[ld_tbl[i]] = b;
            if (we[13]) nxt[3] = alu;
        end
        @(posedge clk);
        m = nxt;
        #1;
        reset = 1'b0; write_en = 16'h0; inc_en = 8'h0;
        check_all();
    endtask

    task automatic probe(input string tag, input logic [3:0] code, input logic [15:0] exp);
        read_en = code;
        #1;
        chk(tag, bus, exp);
    endtask

    initial begin
        foreach (m[i]) m[i] = 16'h0;
        reset = 1'b1; read_en = 4'h0; write_en = 16'h0; inc_en = 8'h0;
        alu_result = 16'h0; iram_rdata = 16'h0; dram_rdata = 16'h0;
        @(negedge clk);

        // Reset after preload
        step(1, 4'd0, 16'h0000, 8'h00, 16'h0, 16'h0, 16'h0);
        step(0, 4'd13, 16'h0010, 8'h00, 16'h0, 16'h1234, 16'h0);
        step(0, 4'd13, 16'h0002, 8'h00, 16'h0, 16'h0005, 16'h0);
        chk("preload_ac", alu_a, 16'h1234);
        chk("preload_pc", iram_addr, 16'h0005);
        step(1, 4'd13, 16'h0012, 8'h06, 16'h0, 16'h7777, 16'h0);
        chk("rst_z", z, 16'h0001);
        chk("rst_iram_addr", iram_addr, 16'h0000);
        chk("rst_ac", alu_a, 16'h0000);

        // Bus load into R1
        step(0, 4'd13, 16'h0010, 8'h00, 16'h0, 16'h00A5, 16'h0);
        step(0, 4'd5, 16'h0040, 8'h00, 16'h0, 16'h0, 16'h0);
        probe("r1_loaded", 4'd7, 16'h00A5);
        probe("r2_untouched", 4'd8, 16'h0000);

        // Memory path
        step(0, 4'd13, 16'h0004, 8'h00, 16'h0, 16'h0010, 16'h0);
        step(0, 4'd12, 16'h0010, 8'h00, 16'h0, 16'h0, 16'hBEEF);
        step(0, 4'd12, 16'h0010, 8'h00, 16'h0, 16'h0, 16'hBEEF);
        chk("mem_ac", alu_a, 16'hBEEF);
        chk("mem_z", z, 16'h0000);
        write_en = 16'h0800; #1;
        chk("mem_we", {15'h0, dram_we}, 16'h0001);
        step(0, 4'd0, 16'h0800, 8'h00, 16'h0, 16'h0, 16'h0);
        chk("mem_daddr", dram_addr, 16'h0010);
        chk("mem_wdata", dram_wdata, 16'hBEEF);

        // Increment and wrap
        step(0, 4'd13, 16'h0002, 8'h00, 16'h0, 16'hFFFF, 16'h0);
        step(0, 4'd0, 16'h0000, 8'h02, 16'h0, 16'h0, 16'h0);
        chk("pc_wrap", iram_addr, 16'h0000);
        step(0, 4'd13, 16'h0100, 8'h00, 16'h0, 16'h0007, 16'h0);
        step(0, 4'd0, 16'h0000, 8'h40, 16'h0, 16'h0, 16'h0);
        probe("r3_inc", 4'd9, 16'h0008);
        step(0, 4'd13, 16'h0010, 8'h00, 16'h0, 16'hFFFF, 16'h0);
        step(0, 4'd0, 16'h0000, 8'h04, 16'h0, 16'h0, 16'h0);
        chk("ac_wrap", alu_a, 16'h0000);
        chk("ac_wrap_z", z, 16'h0001);

        // Priority
        step(0, 4'd13, 16'h0002, 8'h00, 16'h0, 16'h0003, 16'h0);
        step(0, 4'd13, 16'h0002, 8'h02, 16'h0, 16'h0040, 16'h0);
        chk("ld_over_inc", iram_addr, 16'h0040);
        step(0, 4'd13, 16'h2010, 8'h00, 16'h0009, 16'h0055, 16'h0);
        chk("alu_over_bus", alu_a, 16'h0009);

        // Unmapped codes/bits
        step(0, 4'd3, 16'h0000, 8'h00, 16'h0, 16'h1111, 16'h2222);
        step(0, 4'd14, 16'hD001, 8'h81, 16'h0, 16'h1111, 16'h2222);
        step(0, 4'd15, 16'h0000, 8'h00, 16'h0, 16'h1111, 16'h2222);
        chk("unmapped_pc", iram_addr, 16'h0040);
        chk("unmapped_ac", alu_a, 16'h0009);

        // Randomized traffic against the model
        for (int n = 0; n < 200; n++) begin
            logic [15:0] we_r;
            logic [15:0] dat;
            we_r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            dat  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            step(($urandom_range(0, 31) == 0), 4'($urandom), we_r,
                 8'($urandom) & 8'($urandom), 16'($urandom), dat, 16'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/datapath_regs.md
Name: datapath_regs

Overview:
- Register bank and shared-bus datapath that sits directly downstream of the processor control FSM.
- Consumes the FSM's read_en bus-source code, write_en one-hot load strobes and inc_en increment strobes.
- Holds PC, IR, DAR, AC, R, R1-R5; drives the instruction/data memory interfaces and the ALU operands.
- Returns the instruction word and the zero flag to the FSM.

Parameters:
- DATA_W, 16, width of bus, all registers and memory data
- ADDR_W, 16, width of PC/DAR-driven memory addresses (low ADDR_W bits used)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- read_en  input  4  bus source select code
- write_en  input  16  one-hot register load strobes
- inc_en  input  8  register increment strobes
- alu_result  input  DATA_W  ALU output
- iram_rdata  input  DATA_W  instruction memory read data
- dram_rdata  input  DATA_W  data memory read data
- iram_addr  output  ADDR_W  = PC
- dram_addr  output  ADDR_W  = DAR
- dram_wdata  output  DATA_W  = AC
- dram_we  output  1  data memory write strobe
- alu_a  output  DATA_W  = AC
- alu_b  output  DATA_W  = R
- instruction  output  DATA_W  = IR
- z  output  DATA_W  {DATA_W-1 zeros, (AC==0)}
- bus  output  DATA_W  current bus value (debug)

Behaviour:
- Single clock; reset is synchronous and active-high: on a rising clk with reset=1, all registers (PC, IR, DAR, AC, R, R1-R5) clear to 0; strobes are ignored that cycle.
- Bus is combinational from read_en:
  - 2=DAR, 5=AC, 6=R, 7=R1, 8=R2, 9=R3, 10=R4, 11=R5
  - 12=dram_rdata, 13=iram_rdata
  - 0 and all other codes -> 0
- write_en bit map, each load takes effect on the next rising edge:
  - bit1 PC<=bus, bit2 DAR<=bus, bit3 IR<=bus, bit4 AC<=bus, bit5 R<=bus
  - bits6..10 R1..R5<=bus
  - bit11 dram_we=1 (combinational, same cycle as strobe)
  - bit13 AC<=alu_result
  - bits 0, 12, 14, 15 ignored
- inc_en bit map, +1 modulo 2^DATA_W (wraps all-ones -> 0):
  - bit1 PC, bit2 AC, bit3 DAR, bit4 R1, bit5 R2, bit6 R3
  - bits 0 and 7 ignored
- Multiple bits active:
  - Strobes on different registers act independently in the same cycle.
  - Load and increment on the same register in one cycle: the load wins.
  - AC with both bit4 and bit13 set: bit13 (alu_result) wins.
- Outputs iram_addr, dram_addr, dram_wdata, alu_a, alu_b, instruction and z are combinational views of the registers. They update the cycle after a load (1-cycle latency).
- Memories are external, with registered read data. The FSM holds read_en for 2 cycles and repeats the write strobe, so a register load with a stable bus source is idempotent.
- No handshakes. Reset mid-instruction clears state immediately; the FSM is responsible for re-fetching.

Test Plan:
- Reset: preload AC=0x1234, PC=0x0005, assert reset 1 cycle -> all registers 0; z=0x0001; iram_addr=0.
- Bus/load: drive read_en=5 with AC=0x00A5, write_en bit6 -> R1=0x00A5 after 1 edge; bus=0x00A5 during strobe; other registers unchanged.
- Memory path: DAR=0x0010, dram_rdata=0xBEEF, read_en=12, write_en bit4 for 2 cycles -> AC=0xBEEF, z=0. Then write_en bit11 -> dram_we=1, dram_addr=0x0010, dram_wdata=0xBEEF.
- Increment/wrap: PC=0xFFFF, inc_en bit1 -> PC=0x0000. R3=7, inc_en bit6 -> R3=8. AC=0xFFFF, inc_en bit2 -> AC=0, z=0x0001.
- Priority: PC=3, bus=0x0040 (read_en=13), write_en bit1 and inc_en bit1 together -> PC=0x0040. alu_result=0x0009 with write_en bits 4 and 13 -> AC=0x0009.
- Unmapped codes: read_en=3, 14 and 15 -> bus=0. write_en bits 0/12/14/15 and inc_en bits 0/7 -> no register change.
